// File: rtl/mem_arbiter_pkg.sv
// Shared constants, types and helpers for the memory arbiter.
// Holds the boolean/direction flags, address/data types and the FSM state encoding.
package mem_arbiter_pkg;

  localparam logic TRUE       = 1'b1;
  localparam logic FALSE      = 1'b0;
  localparam logic READ_FLAG  = 1'b0;
  localparam logic WRITE_FLAG = 1'b1;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int STATE_W = 2;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_t;

  // Byte lane idx of a little-endian word.
  function automatic logic [7:0] get_byte(input data_t word, input logic [2:0] idx);
    case (idx)
      3'd0:    return word[7:0];
      3'd1:    return word[15:8];
      3'd2:    return word[23:16];
      default: return word[31:24];
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Byte-serial memory arbiter between instruction fetch and the LSU.
// Requests are one-cycle pulses (held in a per-requester pending slot); finish is a one-cycle pulse.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter addr_t IO_BASE = 32'h30000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rdy,
  input  logic       if_req,
  input  addr_t      if_addr,
  output logic       if_finish,
  output data_t      if_data,
  input  logic       lsu_req,
  input  addr_t      lsu_addr,
  input  data_t      lsu_wdata,
  input  logic       lsu_rw,
  input  logic [2:0] lsu_size,
  output logic       lsu_finish,
  output data_t      lsu_rdata,
  input  logic       misbranch,
  input  logic [7:0] mem_din,
  output logic [7:0] mem_dout,
  output addr_t      mem_a,
  output logic       mem_wr,
  input  logic       io_buffer_full,
  output state_t     dbg_state
);

  state_t     state_q, state_d;
  logic [2:0] idx_q;
  addr_t      cur_addr;
  logic [2:0] cur_size;
  logic       cur_lsu;
  data_t      cur_data;
  logic [23:0] rd_buf;

  logic       if_pend;
  addr_t      if_pend_addr;
  logic       lsu_pend;
  addr_t      lsu_pend_addr;
  data_t      lsu_pend_wdata;
  logic       lsu_pend_rw;
  logic [2:0] lsu_pend_size;

  logic       accept_lsu, accept_if, rd_done;
  data_t      rd_word;

  // A pending request is older than a pulse arriving now, so it is served first.
  addr_t      lsu_sel_addr, lsu_sel_wdata, if_sel_addr;
  logic       lsu_sel_rw;
  logic [2:0] lsu_sel_size;
  assign lsu_sel_addr  = lsu_pend ? lsu_pend_addr  : lsu_addr;
  assign lsu_sel_wdata = lsu_pend ? lsu_pend_wdata : lsu_wdata;
  assign lsu_sel_rw    = lsu_pend ? lsu_pend_rw    : lsu_rw;
  assign lsu_sel_size  = lsu_pend ? lsu_pend_size  : lsu_size;
  assign if_sel_addr   = if_pend  ? if_pend_addr   : if_addr;

  addr_t byte_addr;
  logic  io_stall, last_wr;
  assign byte_addr = cur_addr + addr_t'(idx_q);
  assign io_stall  = (byte_addr >= IO_BASE) && io_buffer_full;
  assign last_wr   = (idx_q == cur_size - 3'd1);
  assign dbg_state = state_q;

  always_comb begin
    state_d    = state_q;
    accept_lsu = 1'b0;
    accept_if  = 1'b0;
    rd_done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!misbranch) begin
          if (lsu_pend || lsu_req) begin
            accept_lsu = 1'b1;
            state_d    = (lsu_sel_rw == WRITE_FLAG) ? WRITE : READ;
          end else if (if_pend || if_req) begin
            accept_if = 1'b1;
            state_d   = READ;
          end
        end
      end
      READ: begin
        if (misbranch) begin
          state_d = IDLE;
        end else if (idx_q == cur_size) begin
          rd_done = 1'b1;
          state_d = IDLE;
        end
      end
      WRITE: begin
        if (!io_stall && last_wr) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The last byte is taken straight from mem_din on the finishing edge.
  always_comb begin
    rd_word = '0;
    case (cur_size)
      3'd1:    rd_word = {24'b0, mem_din};
      3'd2:    rd_word = {16'b0, mem_din, rd_buf[7:0]};
      default: rd_word = {mem_din, rd_buf};
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else if (rdy) state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q          <= '0;
      cur_addr       <= '0;
      cur_size       <= '0;
      cur_lsu        <= 1'b0;
      cur_data       <= '0;
      rd_buf         <= '0;
      if_pend        <= 1'b0;
      if_pend_addr   <= '0;
      lsu_pend       <= 1'b0;
      lsu_pend_addr  <= '0;
      lsu_pend_wdata <= '0;
      lsu_pend_rw    <= READ_FLAG;
      lsu_pend_size  <= '0;
      mem_a          <= '0;
      mem_dout       <= '0;
      mem_wr         <= 1'b0;
      if_finish      <= 1'b0;
      lsu_finish     <= 1'b0;
      if_data        <= '0;
      lsu_rdata      <= '0;
    end else if (rdy) begin
      if_finish  <= 1'b0;
      lsu_finish <= 1'b0;
      mem_wr     <= 1'b0;
      mem_a      <= '0;

      if (misbranch) begin
        if_pend  <= 1'b0;
        lsu_pend <= 1'b0;
      end else begin
        if (lsu_req && !(accept_lsu && !lsu_pend)) begin
          lsu_pend       <= 1'b1;
          lsu_pend_addr  <= lsu_addr;
          lsu_pend_wdata <= lsu_wdata;
          lsu_pend_rw    <= lsu_rw;
          lsu_pend_size  <= lsu_size;
        end else if (accept_lsu) begin
          lsu_pend <= 1'b0;
        end
        if (if_req && !(accept_if && !if_pend)) begin
          if_pend      <= 1'b1;
          if_pend_addr <= if_addr;
        end else if (accept_if) begin
          if_pend <= 1'b0;
        end
      end

      case (state_q)
        IDLE: begin
          if (accept_lsu) begin
            cur_addr <= lsu_sel_addr;
            cur_size <= lsu_sel_size;
            cur_data <= lsu_sel_wdata;
            cur_lsu  <= 1'b1;
            idx_q    <= '0;
            rd_buf   <= '0;
          end else if (accept_if) begin
            cur_addr <= if_sel_addr;
            cur_size <= 3'd4;
            cur_data <= '0;
            cur_lsu  <= 1'b0;
            idx_q    <= '0;
            rd_buf   <= '0;
          end
        end
        READ: begin
          if (!misbranch) begin
            if (idx_q < cur_size) mem_a <= byte_addr;
            case (idx_q)
              3'd1:    rd_buf[7:0]   <= mem_din;
              3'd2:    rd_buf[15:8]  <= mem_din;
              3'd3:    rd_buf[23:16] <= mem_din;
              default: ;
            endcase
            if (rd_done) begin
              if (cur_lsu) begin
                lsu_finish <= 1'b1;
                lsu_rdata  <= rd_word;
              end else begin
                if_finish <= 1'b1;
                if_data   <= rd_word;
              end
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end
        end
        WRITE: begin
          // A full IO buffer stalls the current byte without strobing it.
          if (!io_stall) begin
            mem_wr   <= 1'b1;
            mem_a    <= byte_addr;
            mem_dout <= get_byte(cur_data, idx_q);
            if (last_wr) lsu_finish <= 1'b1;
            else idx_q <= idx_q + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table of single transfers plus hand-built corner sequences.
// Byte-wide RAM with combinational read; all writes are checked against an expected queue.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       rdy;
  logic       if_req;
  addr_t      if_addr;
  logic       if_finish;
  data_t      if_data;
  logic       lsu_req;
  addr_t      lsu_addr;
  data_t      lsu_wdata;
  logic       lsu_rw;
  logic [2:0] lsu_size;
  logic       lsu_finish;
  data_t      lsu_rdata;
  logic       misbranch;
  logic [7:0] mem_din;
  logic [7:0] mem_dout;
  addr_t      mem_a;
  logic       mem_wr;
  logic       io_buffer_full;
  state_t     dbg_state;

  mem_arbiter dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .if_req(if_req), .if_addr(if_addr), .if_finish(if_finish), .if_data(if_data),
    .lsu_req(lsu_req), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_rw(lsu_rw),
    .lsu_size(lsu_size), .lsu_finish(lsu_finish), .lsu_rdata(lsu_rdata),
    .misbranch(misbranch), .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a),
    .mem_wr(mem_wr), .io_buffer_full(io_buffer_full), .dbg_state(dbg_state)
  );

  // ---------------- clock / memory model ----------------
  always #5 clk = ~clk;

  logic [7:0] ram [0:4095];
  assign mem_din = ram[mem_a[11:0]];
  always @(posedge clk) if (mem_wr && mem_a < 32'h30000) ram[mem_a[11:0]] <= mem_dout;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int if_fin_cnt = 0;
  int lsu_fin_cnt = 0;
  logic [39:0] exp_q[$];
  addr_t a_log [0:15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mem_wr) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL mem_write: got unexpected write %0h=%0h expected none", mem_a, mem_dout);
      end else begin
        check("mem_write", {mem_a, mem_dout}, exp_q.pop_front());
      end
    end
    if (if_finish) if_fin_cnt++;
    if (lsu_finish) lsu_fin_cnt++;
    if (if_finish || lsu_finish) check("finish_exclusive", if_finish & lsu_finish, 0);
  end

  // ---------------- driver tasks ----------------
  task automatic wait_done(input bit is_if, input int mb_k, input int io_lo, input int io_hi,
                           input int budget, output int lat, output bit ok);
    ok  = 1'b0;
    lat = 0;
    for (int k = 0; k < budget; k++) begin
      if (k < 16) a_log[k] = mem_a;
      if (is_if ? if_finish : lsu_finish) begin
        ok  = 1'b1;
        lat = k;
        break;
      end
      misbranch      = (k == mb_k);
      io_buffer_full = (k >= io_lo && k <= io_hi);
      @(negedge clk);
    end
    misbranch      = 1'b0;
    io_buffer_full = 1'b0;
    if (ok) begin
      @(negedge clk);
      check("finish_one_cycle", is_if ? if_finish : lsu_finish, 0);
      check("idle_mem_a", mem_a, 0);
      check("idle_mem_wr", mem_wr, 0);
    end
  endtask

  task automatic lsu_op(input logic rw, input logic [2:0] size, input addr_t addr, input data_t wdata,
                        input int mb_k, input int io_lo, input int io_hi,
                        output data_t rdata, output int lat, output bit ok);
    addr_t ba;
    if (rw == WRITE_FLAG)
      for (int b = 0; b < int'(size); b++) begin
        ba = addr + addr_t'(b);
        exp_q.push_back({ba, wdata[8*b +: 8]});
      end
    @(negedge clk);
    lsu_req = 1'b1; lsu_rw = rw; lsu_size = size; lsu_addr = addr; lsu_wdata = wdata;
    @(negedge clk);
    lsu_req = 1'b0;
    wait_done(1'b0, mb_k, io_lo, io_hi, 30, lat, ok);
    rdata = lsu_rdata;
  endtask

  task automatic if_op(input addr_t addr, output data_t rdata, output int lat, output bit ok);
    @(negedge clk);
    if_req = 1'b1; if_addr = addr;
    @(negedge clk);
    if_req = 1'b0;
    wait_done(1'b1, -1, 1, 0, 30, lat, ok);
    rdata = if_data;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       is_if;
    logic       rw;
    logic [2:0] size;
    addr_t      addr;
    data_t      wdata;
    data_t      exp_data;
    int         exp_lat;
  } vec_t;

  vec_t vecs [11];

  initial begin
    data_t rdata;
    int    lat;
    bit    ok;
    int    fin_before;

    vecs[0]  = '{1'b0, READ_FLAG,  3'd4, 32'h100, 32'h0,        32'h44332211, 5};
    vecs[1]  = '{1'b0, READ_FLAG,  3'd1, 32'h102, 32'h0,        32'h00000033, 2};
    vecs[2]  = '{1'b0, READ_FLAG,  3'd2, 32'h101, 32'h0,        32'h00003322, 3};
    vecs[3]  = '{1'b0, WRITE_FLAG, 3'd4, 32'h200, 32'hDEADBEEF, 32'h0,        4};
    vecs[4]  = '{1'b0, READ_FLAG,  3'd4, 32'h200, 32'h0,        32'hDEADBEEF, 5};
    vecs[5]  = '{1'b0, WRITE_FLAG, 3'd2, 32'h300, 32'h1234ABCD, 32'h0,        2};
    vecs[6]  = '{1'b0, READ_FLAG,  3'd2, 32'h300, 32'h0,        32'h0000ABCD, 3};
    vecs[7]  = '{1'b1, READ_FLAG,  3'd4, 32'h200, 32'h0,        32'hDEADBEEF, 5};
    vecs[8]  = '{1'b0, WRITE_FLAG, 3'd1, 32'h301, 32'hFFFFFF77, 32'h0,        1};
    vecs[9]  = '{1'b0, READ_FLAG,  3'd4, 32'h300, 32'h0,        32'h000077CD, 5};
    vecs[10] = '{1'b0, READ_FLAG,  3'd1, 32'h103, 32'h0,        32'h00000044, 2};

    for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
    ram[12'h100] = 8'h11; ram[12'h101] = 8'h22; ram[12'h102] = 8'h33; ram[12'h103] = 8'h44;

    // ---------------- reset ----------------
    rst = 1'b0; rdy = 1'b1; if_req = 1'b0; if_addr = '0; lsu_req = 1'b0; lsu_addr = '0;
    lsu_wdata = '0; lsu_rw = READ_FLAG; lsu_size = 3'd0; misbranch = 1'b0; io_buffer_full = 1'b0;
    #12;
    check("rst_mem_a", mem_a, 0);
    check("rst_mem_wr", mem_wr, 0);
    check("rst_mem_dout", mem_dout, 0);
    check("rst_finishes", {if_finish, lsu_finish}, 0);
    check("rst_if_data", if_data, 0);
    check("rst_lsu_rdata", lsu_rdata, 0);
    check("rst_state", dbg_state, IDLE);
    @(negedge clk);
    rst = 1'b1;

    // ---------------- table-driven transfers ----------------
    for (int i = 0; i < 11; i++) begin
      if (vecs[i].is_if) if_op(vecs[i].addr, rdata, lat, ok);
      else lsu_op(vecs[i].rw, vecs[i].size, vecs[i].addr, vecs[i].wdata, -1, 1, 0, rdata, lat, ok);
      check($sformatf("vec%0d_done", i), ok, 1);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
      if (vecs[i].rw == READ_FLAG) check($sformatf("vec%0d_data", i), rdata, vecs[i].exp_data);
    end

    // ---------------- LSU beats a simultaneous fetch ----------------
    @(negedge clk);
    exp_q.push_back({32'h200, 8'hAB});
    if_req = 1'b1; if_addr = 32'h100;
    lsu_req = 1'b1; lsu_rw = WRITE_FLAG; lsu_size = 3'd1; lsu_addr = 32'h200; lsu_wdata = 32'h000000AB;
    @(negedge clk);
    if_req = 1'b0; lsu_req = 1'b0;
    check("prio_if_not_first", if_finish, 0);
    wait_done(1'b0, -1, 1, 0, 20, lat, ok);
    check("prio_sb_done", ok, 1);
    check("prio_sb_latency", lat, 1);
    wait_done(1'b1, -1, 1, 0, 20, lat, ok);
    check("prio_if_done", ok, 1);
    check("prio_if_latency", lat, 5);
    check("prio_if_data", if_data, 32'h44332211);

    // ---------------- IO write stalled by a full buffer ----------------
    wr_cnt = 0;
    lsu_op(WRITE_FLAG, 3'd4, 32'h30000, 32'h01020304, -1, 2, 4, rdata, lat, ok);
    check("io_done", ok, 1);
    check("io_latency", lat, 7);
    check("io_write_count", wr_cnt, 4);

    // ---------------- misbranch aborts a fetch and drops the pending load ----------------
    fin_before = if_fin_cnt + lsu_fin_cnt;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h100;
    @(negedge clk);
    if_req = 1'b0;
    lsu_req = 1'b1; lsu_rw = READ_FLAG; lsu_size = 3'd4; lsu_addr = 32'h100;
    @(negedge clk);
    lsu_req = 1'b0;
    @(negedge clk);
    misbranch = 1'b1;
    @(negedge clk);
    misbranch = 1'b0;
    check("mb_state_idle", dbg_state, IDLE);
    check("mb_no_if_finish", if_finish, 0);
    check("mb_mem_a", mem_a, 0);
    check("mb_mem_wr", mem_wr, 0);
    repeat (12) @(negedge clk);
    check("mb_no_finish_later", if_fin_cnt + lsu_fin_cnt, fin_before);
    check("mb_state_still_idle", dbg_state, IDLE);

    // ---------------- misbranch does not abort a store ----------------
    lsu_op(WRITE_FLAG, 3'd2, 32'h400, 32'h00005566, 0, 1, 0, rdata, lat, ok);
    check("mb_sh_done", ok, 1);
    check("mb_sh_latency", lat, 2);

    // ---------------- reset mid-load, then a wrapping halfword ----------------
    @(negedge clk);
    lsu_req = 1'b1; lsu_rw = READ_FLAG; lsu_size = 3'd4; lsu_addr = 32'h100;
    @(negedge clk);
    lsu_req = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_busy_addr", mem_a, 32'h101);
    fin_before = lsu_fin_cnt;
    rst = 1'b0;
    #1;
    check("midrst_mem_a", mem_a, 0);
    check("midrst_lsu_rdata", lsu_rdata, 0);
    check("midrst_if_data", if_data, 0);
    check("midrst_state", dbg_state, IDLE);
    @(negedge clk);
    rst = 1'b1;
    repeat (8) @(negedge clk);
    check("midrst_no_finish", lsu_fin_cnt, fin_before);
    ram[12'hFFF] = 8'h5A;
    ram[12'h000] = 8'hC3;
    lsu_op(READ_FLAG, 3'd2, 32'hFFFFFFFF, 32'h0, -1, 1, 0, rdata, lat, ok);
    check("wrap_done", ok, 1);
    check("wrap_latency", lat, 3);
    check("wrap_data", rdata, 32'h0000C35A);
    check("wrap_addr0", a_log[1], 32'hFFFFFFFF);
    check("wrap_addr1", a_log[2], 32'h00000000);

    repeat (2) @(negedge clk);
    check("writes_all_seen", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter IO_BASE, default 32'h30000, SHALL mark the first address of the IO region; addresses >= IO_BASE are IO.
REQ-002 clk  in  1  SHALL be the single clock; every flop samples on its rising edge.
REQ-003 rst  in  1  SHALL be the reset, asynchronous and active-low (0 = reset).
REQ-004 rdy  in  1  SHALL be the global ready; when 0, all state SHALL hold.
REQ-005 if_req  in  1  SHALL be the one-cycle fetch request pulse; if_addr  in  32  SHALL be its address (always a 4-byte read).
REQ-006 if_finish  out  1  SHALL be the fetch-done pulse; if_data  out  32  SHALL be the fetched word.
REQ-007 lsu_req  in  1  SHALL be the one-cycle LSU request pulse.
REQ-008 lsu_addr  in  32  SHALL be the LSU address.
REQ-009 lsu_wdata  in  32  SHALL be the LSU store data.
REQ-010 lsu_rw  in  1  SHALL be the LSU direction (READ_FLAG / WRITE_FLAG).
REQ-011 lsu_size  in  3  SHALL be the LSU byte count: 1, 2 or 4.
REQ-012 lsu_finish  out  1  SHALL be the LSU-done pulse; lsu_rdata  out  32  SHALL be the zero-extended read data.
REQ-013 misbranch  in  1  SHALL be the flush indication.
REQ-014 mem_din  in  8  SHALL be the RAM read byte; mem_dout  out  8  SHALL be the RAM write byte.
REQ-015 mem_a  out  32  SHALL be the RAM byte address; mem_wr  out  1  SHALL be the RAM write strobe (1 = write).
REQ-016 io_buffer_full  in  1  SHALL indicate that the IO write buffer is full.

Function
REQ-017 All outputs SHALL be registered.
REQ-018 The block SHALL latch an arriving request pulse into a pending slot (one slot per requester) unless the pulse is accepted directly in the same cycle.
REQ-019 The FSM SHALL have exactly the states IDLE, READ and WRITE.
REQ-020 In IDLE, the block SHALL accept a pending or arriving LSU request before an IF request; when both are present, IF SHALL remain pending.
REQ-021 On acceptance, the block SHALL latch addr, size (IF = 4), direction and data, clear idx, and enter READ or WRITE.
REQ-022 READ: at each edge with idx < N, mem_a SHALL be set to addr+idx with mem_wr=0; at each edge with idx >= 1, byte idx-1 SHALL be captured from mem_din.
REQ-023 READ: the finish pulse and data SHALL be asserted N+1 edges after the acceptance edge, after which the FSM SHALL return to IDLE.
REQ-024 WRITE: at edges 0..N-1, mem_wr=1, mem_a=addr+idx and mem_dout=data[8*idx+7:8*idx] SHALL be driven; lsu_finish SHALL be pulsed N edges after acceptance, with mem_wr=0 from then on.
REQ-025 WRITE to an IO address while io_buffer_full=1: the block SHALL drive mem_wr=0 and hold idx until io_buffer_full=0.
REQ-026 Byte addresses SHALL wrap modulo 2^32.
REQ-027 Unused bytes of lsu_rdata SHALL be 0; sign extension is the LSU's responsibility.
REQ-028 Each finish output SHALL be high for exactly one cycle per accepted request; if_finish and lsu_finish SHALL never both be high in the same cycle.
REQ-029 misbranch=1: an in-flight READ SHALL be aborted (no finish, return to IDLE, mem_wr=0) and both pending slots SHALL be cleared.
REQ-030 misbranch=1: an in-flight WRITE SHALL complete and pulse lsu_finish.
REQ-031 A request pulse coinciding with misbranch=1 SHALL be dropped.
REQ-032 Between accesses, the block SHALL drive mem_a=0 and mem_wr=0.

Reset
REQ-033 rst=0 SHALL asynchronously force state=IDLE, clear the pending slots and idx, and set mem_a=0, mem_dout=0, mem_wr=0, if_finish=0, lsu_finish=0, if_data=0, lsu_rdata=0.
REQ-034 Reset asserted mid-transfer SHALL abandon the transfer with no finish pulse.

Structure
REQ-035 TRUE/FALSE, READ_FLAG/WRITE_FLAG, ADDR_TYPE/DATA_TYPE and the FSM state width SHALL reside in the shared constant.v.
REQ-036 No sub-module is warranted; the block SHALL be a single flat module.

Verification
REQ-037 LW at 0x100, RAM bytes 11,22,33,44: lsu_finish SHALL rise 5 edges after acceptance with lsu_rdata=0x44332211.
REQ-038 if_req and lsu_req (SB 0x200, data 0xAB) pulsed in the same cycle: the SB SHALL write 0xAB first with lsu_finish after 1 edge; the fetch SHALL then start and if_finish SHALL follow.
REQ-039 SW 0x30000 with io_buffer_full high for 3 cycles after byte 1: exactly 4 mem_wr cycles SHALL occur, and lsu_finish SHALL come 7 edges after acceptance.
REQ-040 Fetch in flight with misbranch pulsed at idx=2: there SHALL be no if_finish, IDLE SHALL be reached the next edge, and the pending LSU read SHALL be discarded.
REQ-041 SH in flight with misbranch: both bytes SHALL be written and lsu_finish SHALL pulse.
REQ-042 rst low mid-LW: outputs SHALL be zeroed immediately, and after release a new LHU at 0xFFFFFFFF SHALL read addresses FFFFFFFF and 00000000.
